// File: rtl/ldpc_pkg.sv
// ============================================================================
// Module   : ldpc_pkg
// Purpose  : Shared constants, message type, variable-node FSM states and the
//            -128 input clamp used by both the variable- and check-node passes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ldpc_pkg;

  localparam int W     = 8;     // message / LLR width, two's complement
  localparam int DV    = 3;     // variable-node degree
  localparam int DC    = 6;     // check-node degree
  localparam int N_VAR = 128;   // variable nodes per frame
  localparam int AW    = 10;    // message RAM address width
  localparam int ACC_W = W + 2; // llr + DV messages never overflow this

  typedef logic signed [W-1:0] msg_t;

  // Largest legal magnitudes; the most-negative code is reserved.
  localparam msg_t MSG_POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam msg_t MSG_NEG_MAX = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam msg_t MSG_MIN     = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    ACC  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } vnp_state_t;

  // The check pass takes |x|, so the asymmetric minimum is folded to -127.
  function automatic msg_t clamp127(input msg_t x);
    return (x == MSG_MIN) ? MSG_NEG_MAX : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vnp_if.sv
// ============================================================================
// Module   : vnp_if
// Purpose  : Channel-LLR RAM and message RAM port bundle of the variable-node
//            processor. Hard-decision signals exist only when VNP_HARD_DEC_EN
//            is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface vnp_if;
  import ldpc_pkg::*;

  logic [6:0]    llr_addr;
  msg_t          llr_din;
  logic [AW-1:0] mess_addra;
  logic [AW-1:0] mess_addrb;
  msg_t          mess_din;
  msg_t          mess_dout;
  logic          mess_web;
`ifdef VNP_HARD_DEC_EN
  logic          hard_bit;
  logic          hard_we;
`endif

`ifdef VNP_HARD_DEC_EN
  modport master (
    output llr_addr, mess_addra, mess_addrb, mess_dout, mess_web, hard_bit, hard_we,
    input  llr_din, mess_din
  );
  modport slave (
    input  llr_addr, mess_addra, mess_addrb, mess_dout, mess_web, hard_bit, hard_we,
    output llr_din, mess_din
  );
`else
  modport master (
    output llr_addr, mess_addra, mess_addrb, mess_dout, mess_web,
    input  llr_din, mess_din
  );
  modport slave (
    input  llr_addr, mess_addra, mess_addrb, mess_dout, mess_web,
    output llr_din, mess_din
  );
`endif

endinterface

`default_nettype wire

// File: rtl/vnp_sat_sub.sv
// ============================================================================
// Module   : vnp_sat_sub
// Purpose  : Extrinsic message = total - own incoming message, saturated to
//            the symmetric range [-127, +127].
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vnp_sat_sub
  import ldpc_pkg::*;
(
  input  wire logic signed [ACC_W-1:0] acc_i,
  input  wire msg_t                    msg_i,
  output msg_t                         res_o
);

  localparam logic signed [W+2:0] C_HI = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [W+2:0] C_LO = -C_HI;

  logic signed [W+2:0] w_diff;

  // One extra bit over the accumulator covers acc +/- a full-scale message.
  always_comb begin
    w_diff = {acc_i[ACC_W-1], acc_i} - {{3{msg_i[W-1]}}, msg_i};
    if (w_diff > C_HI)
      res_o = MSG_POS_MAX;
    else if (w_diff < C_LO)
      res_o = MSG_NEG_MAX;
    else
      res_o = w_diff[W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/vnp.sv
// ============================================================================
// Module   : vnp
// Purpose  : Variable-node processor for the (3,6) min-sum LDPC decoder.
//            Per node: read DV messages + channel LLR, total them, write DV
//            extrinsic messages back, optionally emit the hard decision.
//            Optional feature macro: VNP_HARD_DEC_EN (hard_bit / hard_we).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vnp
  import ldpc_pkg::*;
#(
  parameter int N_VAR = ldpc_pkg::N_VAR
)(
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic vnp_on,
  input  wire logic ce,
  output logic      process_finish,
  vnp_if.master     bus
);

  vnp_state_t               state_q, state_d;
  logic [6:0]               v_q, v_d;
  logic [1:0]               k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  msg_t                     m_q [DV];
  msg_t                     llr_q;
  logic                     rdv_q;
  logic [1:0]               rdk_q;

  msg_t                     w_m_last;
  msg_t                     w_sat;
  logic [AW-1:0]            w_addr;
  logic                     w_wr;

  function automatic logic signed [ACC_W-1:0] sx(input msg_t x);
    return {{(ACC_W-W){x[W-1]}}, x};
  endfunction

  // Node base address plus message index; read and write share it.
  always_comb begin
    w_addr = AW'(v_q) * AW'(DV) + AW'(k_q);
  end

  // Last message of a node arrives during ACC's first cycle; after a stall
  // in ACC it is taken from the capture buffer instead.
  always_comb begin
    w_m_last = rdv_q ? clamp127(bus.mess_din) : m_q[DV-1];
  end

  // Next-state, counters and accumulator; vnp_on low overrides ce.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    k_d     = k_q;
    acc_d   = acc_q;
    if (!vnp_on) begin
      state_d = IDLE;
      v_d     = '0;
      k_d     = '0;
      acc_d   = '0;
    end else if (ce) begin
      case (state_q)
        IDLE: begin
          state_d = RD;
          v_d     = '0;
          k_d     = '0;
        end
        RD: begin
          if (k_q == 2'(DV-1)) begin
            state_d = ACC;
            k_d     = '0;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
        ACC: begin
          acc_d   = sx(llr_q) + sx(m_q[0]) + sx(m_q[1]) + sx(w_m_last);
          state_d = WR;
          k_d     = '0;
        end
        WR: begin
          if (k_q == 2'(DV-1)) begin
            k_d = '0;
            if (v_q == 7'(N_VAR-1)) begin
              state_d = DONE;
            end else begin
              state_d = RD;
              v_d     = v_q + 7'd1;
            end
          end else begin
            k_d = k_q + 2'd1;
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, node/message counters and node total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  // Read-data capture tracks the address issued on the previous clock, so a
  // stall that holds the address simply re-captures identical data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdv_q <= 1'b0;
      rdk_q <= '0;
      llr_q <= '0;
      for (int i = 0; i < DV; i++) m_q[i] <= '0;
    end else begin
      rdv_q <= vnp_on && (state_q == RD);
      rdk_q <= k_q;
      if (rdv_q) begin
        m_q[rdk_q] <= clamp127(bus.mess_din);
        llr_q      <= clamp127(bus.llr_din);
      end
    end
  end

  vnp_sat_sub u_sat (
    .acc_i (acc_q),
    .msg_i (m_q[k_q]),
    .res_o (w_sat)
  );

  // RAM-side outputs; writes are suppressed by a stall or a pass abort.
  always_comb begin
    w_wr           = vnp_on && ce && (state_q == WR);
    bus.llr_addr   = v_q;
    bus.mess_addra = w_addr;
    bus.mess_addrb = w_addr;
    bus.mess_web   = w_wr;
    bus.mess_dout  = (state_q == WR) ? w_sat : '0;
    process_finish = (state_q == DONE);
`ifdef VNP_HARD_DEC_EN
    bus.hard_bit   = acc_q[ACC_W-1];
    bus.hard_we    = w_wr && (k_q == 2'd0);
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_vnp.sv
// ============================================================================
// Module   : tb_vnp
// Purpose  : Directed, table-driven bench for vnp with a two-node frame.
//            Hard-decision checks are compiled when VNP_HARD_DEC_EN is set.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vnp;
  import ldpc_pkg::*;

  localparam int NV = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vnp_on = 1'b0;
  logic ce = 1'b0;
  logic process_finish;

  always #5 clk = ~clk;

  vnp_if bus();

  vnp #(.N_VAR(NV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vnp_on         (vnp_on),
    .ce             (ce),
    .process_finish (process_finish),
    .bus            (bus)
  );

  // Synchronous-read RAM models: data one clock after the address.
  msg_t msrc [0:5];
  msg_t lsrc [0:1];

  always @(posedge clk) begin
    bus.mess_din <= (bus.mess_addra < AW'(6)) ? msrc[bus.mess_addra[2:0]] : '0;
    bus.llr_din  <= (bus.llr_addr < 7'd2) ? lsrc[bus.llr_addr[0]] : '0;
  end

  typedef struct {
    int llr; int m0; int m1; int m2;
    int e0;  int e1; int e2; int hb;
  } vec_t;

  typedef struct {
    int a; int b; int stall; int abort; int exp_nw; int exp_fin;
  } frm_t;

  vec_t vec [0:5];
  frm_t frm [0:3];

  int checks = 0;
  int errors = 0;

  int nw, first_web, first_addr, fin_cyc, stall_wr, fin_last, nhw;
  int wa [0:7];
  int wd [0:7];
  int hb [0:1];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input int a, input int b);
    lsrc[0] = msg_t'(vec[a].llr);
    msrc[0] = msg_t'(vec[a].m0);
    msrc[1] = msg_t'(vec[a].m1);
    msrc[2] = msg_t'(vec[a].m2);
    lsrc[1] = msg_t'(vec[b].llr);
    msrc[3] = msg_t'(vec[b].m0);
    msrc[4] = msg_t'(vec[b].m1);
    msrc[5] = msg_t'(vec[b].m2);
  endtask

  // Cycle 0 is the cycle in which vnp_on is first seen high.
  task automatic run_frame(input int stall_at, input int abort_at, input int ncyc);
    nw = 0; first_web = -1; first_addr = -1; fin_cyc = -1;
    stall_wr = 0; fin_last = 0; nhw = 0;
    hb[0] = -1; hb[1] = -1;
    @(posedge clk); #1;
    vnp_on = 1'b1;
    ce     = 1'b1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge clk); #1;
      ce = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 4);
      if (cyc == abort_at) vnp_on = 1'b0;
      @(negedge clk);
      if (bus.mess_web) begin
        if (nw < 8) begin
          wa[nw] = int'(bus.mess_addrb);
          wd[nw] = int'(bus.mess_dout);
        end
        if (first_web < 0) begin
          first_web  = cyc;
          first_addr = int'(bus.mess_addrb);
        end
        if (!ce) stall_wr++;
        nw++;
      end
      if (process_finish && fin_cyc < 0) fin_cyc = cyc;
      if (cyc == ncyc) fin_last = int'(process_finish);
`ifdef VNP_HARD_DEC_EN
      if (bus.hard_we) begin
        hb[bus.llr_addr[0]] = int'(bus.hard_bit);
        nhw++;
      end
`endif
    end
    @(posedge clk); #1;
    vnp_on = 1'b0;
    ce     = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  initial begin
    //           llr   m0    m1    m2    e0    e1    e2   hb
    vec[0] = '{  10,    5,   -3,   20,   27,   35,   12,  0};
    vec[1] = '{ 127,  127,  127,  127,  127,  127,  127,  0};
    vec[2] = '{-128, -128, -128, -128, -127, -127, -127,  1};
    vec[3] = '{ -20,    7, -100,    0, -120,  -13, -113,  1};
    vec[4] = '{   0,    0,    0,    0,    0,    0,    0,  0};
    vec[5] = '{ 100,  -50,   60, -127,   33,  -77,  110,  1};

    //          a  b  stall abort nw  fin
    frm[0] = '{0, 1,   -1,   -1,  6,  15};
    frm[1] = '{2, 3,   13,   -1,  6,  19};
    frm[2] = '{4, 5,   -1,    9,  3,  -1};
    frm[3] = '{4, 5,   -1,   -1,  6,  15};

    for (int i = 0; i < 6; i++) msrc[i] = '0;
    lsrc[0] = '0;
    lsrc[1] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_web",    int'(bus.mess_web),   0);
    chk("rst_finish", int'(process_finish), 0);
    chk("rst_addra",  int'(bus.mess_addra), 0);
    chk("rst_addrb",  int'(bus.mess_addrb), 0);
    chk("rst_llr_addr", int'(bus.llr_addr), 0);
    chk("rst_dout",   int'(bus.mess_dout),  0);
    rst_n = 1'b1;
    ce    = 1'b1;

    for (int f = 0; f < 4; f++) begin
      load(frm[f].a, frm[f].b);
      run_frame(frm[f].stall, frm[f].abort, 24);
      chk("write_count", nw, frm[f].exp_nw);
      chk("first_web_cycle", first_web, 5);
      chk("first_web_addr", first_addr, 0);
      chk("finish_cycle", fin_cyc, frm[f].exp_fin);
      chk("stall_write", stall_wr, 0);
      if (frm[f].exp_fin >= 0) chk("finish_hold", fin_last, 1);
      chk("finish_drop", int'(process_finish), 0);
      for (int n = 0; n < frm[f].exp_nw / 3; n++) begin
        vec_t ev;
        ev = (n == 0) ? vec[frm[f].a] : vec[frm[f].b];
        chk("wr_addr", wa[n*3+0], n*3+0);
        chk("wr_addr", wa[n*3+1], n*3+1);
        chk("wr_addr", wa[n*3+2], n*3+2);
        chk("wr_data0", wd[n*3+0], ev.e0);
        chk("wr_data1", wd[n*3+1], ev.e1);
        chk("wr_data2", wd[n*3+2], ev.e2);
`ifdef VNP_HARD_DEC_EN
        chk("hard_bit", hb[n], ev.hb);
`endif
      end
`ifdef VNP_HARD_DEC_EN
      chk("hard_we_count", nhw, frm[f].exp_nw / 3);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
